// File: rtl/complex_mult_pkg.sv
// Shared definitions for the complex multiplier result path: default widths,
// the {re, im} result record and the buffer occupancy classification.
package complex_mult_pkg;

  localparam int DEF_RES_WIDTH  = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  // One complex result at the default component width, real part first so the
  // packed form matches the {real, imaginary} bus layout.
  typedef struct packed {
    logic signed [DEF_RES_WIDTH-1:0] re;
    logic signed [DEF_RES_WIDTH-1:0] im;
  } res_rec_t;

  // Occupancy of the result buffer as seen by producer and consumer.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  // Classify an entry count against the buffer depth.
  function automatic occ_state_t occ_of(input int unsigned count,
                                        input int unsigned depth);
    occ_state_t occ;
    if (count == 0)
      occ = OCC_EMPTY;
    else if (count >= depth)
      occ = OCC_FULL;
    else
      occ = OCC_PARTIAL;
    return occ;
  endfunction

endpackage

// File: rtl/res_fifo_mem.sv
// Result storage for complex_result_buffer: one write port registered on clk,
// one asynchronous read port. Contents are deliberately never reset.
module res_fifo_mem
  import complex_mult_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_RES_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Capture an accepted result into its slot.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/complex_result_buffer.sv
// Elastic buffer between the complex multiplier core and its consumer.
// Valid/ready on both sides; a full buffer refuses new results even when the
// consumer pops in the same cycle, so mult_ready depends only on registered
// state. Optional feature macro: RES_TXN_CNT_EN adds a 16-bit pop counter
// on output res_txn_cnt.
module complex_result_buffer
  import complex_mult_pkg::*;
#(
  parameter int RES_WIDTH  = DEF_RES_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sw_rst,
  input  logic                          mult_val,
  input  logic signed [RES_WIDTH-1:0]   mult_re,
  input  logic signed [RES_WIDTH-1:0]   mult_im,
  output logic                          mult_ready,
  output logic                          res_val,
  input  logic                          res_ready,
  output logic [2*RES_WIDTH-1:0]        res_data,
  output logic [$clog2(FIFO_DEPTH):0]   res_count
`ifdef RES_TXN_CNT_EN
  ,
  output logic [15:0]                   res_txn_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  occ_state_t    occ;
  logic          push;
  logic          pop;

  // Occupancy and handshakes come straight from the registered count.
  always_comb begin
    occ        = occ_of(32'(count), 32'(FIFO_DEPTH));
    mult_ready = (occ != OCC_FULL);
    res_val    = (occ != OCC_EMPTY);
    push       = mult_val && mult_ready;
    pop        = res_val && res_ready;
  end

  // Pointer and count update; soft reset beats any same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (sw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  res_fifo_mem #(
    .WIDTH (2 * RES_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !sw_rst),
    .wr_addr (wr_ptr),
    .wr_data ({mult_re, mult_im}),
    .rd_addr (rd_ptr),
    .rd_data (res_data)
  );

  assign res_count = count;

`ifdef RES_TXN_CNT_EN
  // Count every completed pop, wrapping naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      res_txn_cnt <= '0;
    else if (sw_rst)
      res_txn_cnt <= '0;
    else if (pop)
      res_txn_cnt <= res_txn_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_complex_result_buffer.sv
// Self-checking bench for complex_result_buffer: directed scenarios with
// hand-computed expectations plus a randomized phase, all compared against a
// queue-based model of the buffer.
module tb_complex_result_buffer;
  import complex_mult_pkg::*;

  localparam int RW    = 16;
  localparam int DEPTH = 4;

  logic               clk;
  logic               rst;
  logic               sw_rst;
  logic               mult_val;
  logic signed [RW-1:0] mult_re;
  logic signed [RW-1:0] mult_im;
  logic               mult_ready;
  logic               res_val;
  logic               res_ready;
  logic [2*RW-1:0]    res_data;
  logic [2:0]         res_count;
`ifdef RES_TXN_CNT_EN
  logic [15:0]        res_txn_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit check_en = 0;
  bit capture_en = 0;

  res_rec_t    model_q[$];
  int unsigned model_txn = 0;
  logic [31:0] sent[$];
  logic [31:0] dut_out[$];

  complex_result_buffer #(
    .RES_WIDTH  (RW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst     (sw_rst),
    .mult_val   (mult_val),
    .mult_re    (mult_re),
    .mult_im    (mult_im),
    .mult_ready (mult_ready),
    .res_val    (res_val),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_count  (res_count)
`ifdef RES_TXN_CNT_EN
    ,
    .res_txn_cnt(res_txn_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the clock edge.
  task automatic applyStimulus(input logic val, input logic [RW-1:0] re,
                               input logic [RW-1:0] im, input logic rdy);
    mult_val  = val;
    mult_re   = re;
    mult_im   = im;
    res_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic drainAll();
    int n = 0;
    while (res_count != 0 && n < 2 * DEPTH + 2) begin
      applyStimulus(1'b0, '0, '0, 1'b1);
      n++;
    end
    checkOutput("drain_done", 32'(res_count), 32'd0);
    res_ready = 1'b0;
  endtask

  task automatic softReset();
    sw_rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    sw_rst = 1'b0;
  endtask

  // Reference model: a FIFO of records with a depth limit and a pop tally.
  always @(posedge clk or posedge rst) begin
    bit do_push, do_pop;
    if (rst) begin
      model_q.delete();
      model_txn = 0;
    end else if (sw_rst) begin
      model_q.delete();
      model_txn = 0;
    end else begin
      do_push = mult_val && (model_q.size() < DEPTH);
      do_pop  = res_ready && (model_q.size() > 0);
      if (do_pop) begin
        void'(model_q.pop_front());
        model_txn = (model_txn + 1) % 65536;
      end
      if (do_push)
        model_q.push_back('{re: mult_re, im: mult_im});
    end
  end

  // Record what the consumer actually receives, for ordering checks.
  always @(posedge clk) begin
    if (capture_en && res_val && res_ready)
      dut_out.push_back(res_data);
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int n;
    if (check_en) begin
      n = model_q.size();
      checkOutput("cmp_count", 32'(res_count), 32'(n));
      checkOutput("cmp_res_val", 32'(res_val), 32'(n != 0));
      checkOutput("cmp_mult_ready", 32'(mult_ready), 32'(n != DEPTH));
      if (n != 0)
        checkOutput("cmp_res_data", res_data, {model_q[0].re, model_q[0].im});
`ifdef RES_TXN_CNT_EN
      checkOutput("cmp_txn_cnt", 32'(res_txn_cnt), model_txn);
`endif
    end
  end

  initial begin
    rst = 1'b1;
    sw_rst = 1'b0;
    mult_val = 1'b0;
    mult_re = '0;
    mult_im = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_res_val", 32'(res_val), 32'd0);
    checkOutput("reset_mult_ready", 32'(mult_ready), 32'd1);
    checkOutput("reset_count", 32'(res_count), 32'd0);
    check_en = 1'b1;

    // Single transfer held by a stalled consumer.
    applyStimulus(1'b1, 16'h0003, 16'hFFFE, 1'b0);
    checkOutput("single_latency_val", 32'(res_val), 32'd1);
    for (int i = 0; i < 20; i++) begin
      checkOutput("single_hold_data", res_data, 32'h0003FFFE);
      checkOutput("single_hold_val", 32'(res_val), 32'd1);
      applyStimulus(1'b0, '0, '0, 1'b0);
    end
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("single_after_pop_val", 32'(res_val), 32'd0);
    res_ready = 1'b0;

    // Fill to capacity; value 5 waits for space.
    for (int k = 1; k <= 4; k++)
      applyStimulus(1'b1, 16'(k), 16'(k), 1'b0);
    checkOutput("fill_count4", 32'(res_count), 32'd4);
    checkOutput("fill_not_ready", 32'(mult_ready), 32'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'd5, 16'd5, 1'b0);
    checkOutput("fill_5_rejected", 32'(res_count), 32'd4);
    applyStimulus(1'b1, 16'd5, 16'd5, 1'b1);
    checkOutput("fill_no_passthru", 32'(res_count), 32'd3);
    checkOutput("fill_head_after_pop", res_data, 32'h00020002);
    applyStimulus(1'b1, 16'd5, 16'd5, 1'b0);
    checkOutput("fill_5_accepted", 32'(res_count), 32'd4);
    drainAll();

    // Simultaneous push and pop at count 2.
    applyStimulus(1'b1, 16'h0011, 16'h0022, 1'b0);
    applyStimulus(1'b1, 16'h0033, 16'h0044, 1'b0);
    checkOutput("simul_pre_count", 32'(res_count), 32'd2);
    applyStimulus(1'b1, 16'h0055, 16'h0066, 1'b1);
    checkOutput("simul_count_kept", 32'(res_count), 32'd2);
    checkOutput("simul_head", res_data, 32'h00330044);
    drainAll();

    // Streaming with the consumer always ready, across pointer wrap.
    softReset();
    sent.delete();
    dut_out.delete();
    capture_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [RW-1:0] re, im;
      re = 16'($urandom);
      im = 16'($urandom);
      sent.push_back({re, im});
      applyStimulus(1'b1, re, im, 1'b1);
      checkOutput("stream_count_le1", 32'(res_count <= 3'd1), 32'd1);
    end
    applyStimulus(1'b0, '0, '0, 1'b1);
    drainAll();
    capture_en = 1'b0;
    checkOutput("stream_len", 32'(dut_out.size()), 32'd20);
    for (int i = 0; i < 20; i++)
      checkOutput("stream_order", (i < dut_out.size()) ? dut_out[i] : 32'hDEADBEEF, sent[i]);
`ifdef RES_TXN_CNT_EN
    checkOutput("txn_after_stream", 32'(res_txn_cnt), 32'd20);
    softReset();
    checkOutput("txn_after_swrst", 32'(res_txn_cnt), 32'd0);
`endif

    // Soft reset at count 3 overrides a same-cycle push and pop.
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 16'(k + 16'h0100), 16'(k), 1'b0);
    checkOutput("swrst_pre_count", 32'(res_count), 32'd3);
    sw_rst = 1'b1;
    applyStimulus(1'b1, 16'h7777, 16'h8888, 1'b1);
    sw_rst = 1'b0;
    checkOutput("swrst_count", 32'(res_count), 32'd0);
    checkOutput("swrst_res_val", 32'(res_val), 32'd0);

    // Asynchronous reset between clock edges.
    applyStimulus(1'b1, 16'h0A0A, 16'h0B0B, 1'b0);
    applyStimulus(1'b1, 16'h0C0C, 16'h0D0D, 1'b0);
    mult_val = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_count", 32'(res_count), 32'd0);
    checkOutput("arst_res_val", 32'(res_val), 32'd0);
    checkOutput("arst_mult_ready", 32'(mult_ready), 32'd1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic with occasional soft resets.
    for (int i = 0; i < 500; i++) begin
      sw_rst = ($urandom_range(0, 31) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 2) == 0));
    end
    sw_rst = 1'b0;
    drainAll();

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/complex_result_buffer.md
COMPLEX_RESULT_BUFFER -- requirements
Module: complex_result_buffer

Interface
REQ-001 Parameter RES_WIDTH, default 16: width of each signed result component (real, imaginary).
REQ-002 Parameter FIFO_DEPTH, default 4: result entries held; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 sw_rst  input  1  synchronous soft reset, active-high.
REQ-006 mult_val  input  1  multiplier core presents a valid result.
REQ-007 mult_re  input  RES_WIDTH  result real part, signed.
REQ-008 mult_im  input  RES_WIDTH  result imaginary part, signed.
REQ-009 mult_ready  output  1  buffer accepts a result this cycle.
REQ-010 res_val  output  1  result available to the consumer.
REQ-011 res_ready  input  1  consumer accepts the presented result.
REQ-012 res_data  output  2*RES_WIDTH  {real, imaginary}, real in the upper half.
REQ-013 res_count  output  clog2(FIFO_DEPTH)+1  entries currently held.

Function
REQ-014 Push: mult_val && mult_ready on a rising edge; writes {mult_re, mult_im} at the write pointer.
REQ-015 Pop: res_val && res_ready on a rising edge; advances the read pointer.
REQ-016 mult_ready = (res_count != FIFO_DEPTH). The output is combinational from the registered count. A full buffer does not pass a result through on a simultaneous pop.
REQ-017 res_val = (res_count != 0). res_data is the entry at the read pointer.
REQ-018 Latency: a push into an empty buffer gives res_val=1 and the pushed data on the next cycle.
REQ-019 While res_val && !res_ready, res_data and res_val hold stable.
REQ-020 Occupancy states, derived from res_count: EMPTY (0), PARTIAL (1..FIFO_DEPTH-1), FULL (FIFO_DEPTH).
REQ-021 State transitions:
  - EMPTY to PARTIAL on push.
  - PARTIAL to FULL on a push without a pop at count FIFO_DEPTH-1.
  - PARTIAL to EMPTY on a pop without a push at count 1.
  - FULL to PARTIAL on pop.
REQ-022 Simultaneous push and pop in PARTIAL: count unchanged, both pointers advance, FIFO order is preserved.
REQ-023 Pointers wrap modulo FIFO_DEPTH with no gap or duplicate entry.
REQ-024 mult_val while FULL: no write occurs. The producer holds its data per the valid/ready rule.
REQ-025 Back-to-back pops with res_ready held high drain one entry per cycle.

Reset
REQ-026 rst=1: pointers and res_count go to 0 immediately, so res_val=0 and mult_ready=1. Storage contents are not reset.
REQ-027 sw_rst=1 at a clock edge has the same effect as rst, synchronously.
  - It overrides a push or pop in the same cycle.
  - A held result is discarded.
REQ-028 Reset mid-transaction: the consumer sees res_val fall in the cycle after sw_rst, or immediately on rst.

Configuration
REQ-029 Macro RES_TXN_CNT_EN defined: adds output res_txn_cnt, 16 bits.
  - Increments on every pop and wraps from 0xFFFF to 0.
  - Cleared by rst and sw_rst.
REQ-030 Macro RES_TXN_CNT_EN undefined: res_txn_cnt port and counter are absent. All other behaviour is identical.

Structure
REQ-031 Shared package complex_mult_pkg holds:
  - default RES_WIDTH and FIFO_DEPTH constants;
  - the result record type {re, im}.
REQ-032 Storage is one sub-module, res_fifo_mem: dual-port array with a registered write and an asynchronous read. Pointer, count and handshake logic stay in complex_result_buffer.

Verification
REQ-033 Single transfer: push re=0x0003, im=0xFFFE with res_ready=0 for 20 cycles, then res_ready=1.
  - res_val=1 one cycle after the push.
  - res_data=0x0003FFFE stable throughout.
  - One pop, then res_val=0.
REQ-034 Fill: 5 pushes (values 1..5 in both halves) with res_ready=0, FIFO_DEPTH=4.
  - mult_ready=0 after the 4th push; res_count=4.
  - Value 5 is not accepted until a pop occurs.
REQ-035 Stream: 20 transactions with res_ready held high, pushing every cycle.
  - Output order equals input order.
  - res_count never exceeds 1.
  - No drops across pointer wrap.
REQ-036 Simultaneous push and pop at res_count=2: res_count stays 2 and data order is preserved.
REQ-037 Reset: sw_rst at res_count=3 gives res_count=0 and res_val=0 next cycle. rst asserted mid-cycle clears outputs without a clock edge.
REQ-038 With RES_TXN_CNT_EN defined: after the 20-transaction stream, res_txn_cnt=20; after sw_rst, res_txn_cnt=0.
